spi_host_ctrl: RTL and testbench
================================

Name: spi_host_ctrl

Overview:
Byte-oriented SPI controller (mode 0: CPOL=0, CPHA=0, MSB first). It is the initiator end of the SIMON SPI link. It drives the tile's SPI target for on-chip loopback, and it drives a host-side harness that loads keys and plaintext and reads ciphertext. Bytes are handed over one at a time with a ready/start handshake. cs_n stays asserted across bytes until a byte flagged last completes.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255; SCLK period = 2*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to send tx_data; accepted only in a cycle where tx_ready=1
tx_data  input  8  byte to shift out, MSB first
tx_last  input  1  sampled with start; 1 = release cs_n after this byte
abort  input  1  synchronous abort of the current transaction
tx_ready  output  1  high in IDLE and WAIT; controller can accept a byte
busy  output  1  high whenever state != IDLE
rx_data  output  8  last received byte; holds until the next byte completes
rx_valid  output  1  one-cycle pulse when rx_data updates
sclk  output  1  SPI clock, idles low
mosi  output  1  SPI data out
miso  input  1  SPI data in
cs_n  output  1  SPI chip select, active low

Behaviour:
- Reset (async, rst_n=0) puts every output and internal register to its reset value:
  - state=IDLE, cs_n=1, sclk=0, mosi=0, tx_ready=1, busy=0, rx_data=0x00, rx_valid=0.
  - Bit counter, divider counter and shift registers = 0.
- States: IDLE, LEAD (sclk low half), HIGH (sclk high half), WAIT (between bytes, cs_n low), TRAIL (cs_n hold after last byte).
- Accept: start=1 and tx_ready=1 at clk edge E0. At that edge:
  - load tx shift register, latch tx_last;
  - mosi<=tx_data[7], cs_n<=0, bit counter<=0, divider<=0;
  - go to LEAD.
- Edge timing, relative to E0:
  - SCLK rises at E0+CLK_DIV*(2k+1), k=0..7.
  - SCLK falls at E0+CLK_DIV*(2k+2).
  - Each phase lasts exactly CLK_DIV cycles.
- LEAD->HIGH: sclk<=1. miso is sampled on this same clk edge and shifted into the rx shift register LSB.
- HIGH->LEAD (bits 0..6): sclk<=0, mosi<=next bit, bit counter+1.
- HIGH after bit 7:
  - sclk<=0, rx_data<=assembled byte, rx_valid=1 for exactly one cycle.
  - Then go to TRAIL if latched last=1, else to WAIT.
- WAIT:
  - cs_n=0, sclk=0, mosi holds bit 0 of the previous byte, tx_ready=1.
  - start -> load and go to LEAD on the same rules as from IDLE. Back-to-back bytes are allowed: the next byte's first SCLK rise comes CLK_DIV cycles after acceptance.
- TRAIL: CLK_DIV cycles with cs_n=0, then cs_n<=1, mosi<=0, go to IDLE. Total cs_n low for a single last byte = 17*CLK_DIV cycles.
- start while tx_ready=0 is ignored: no queueing, no error.
- abort=1 in any state:
  - next edge: state=IDLE, cs_n=1, sclk=0, mosi=0;
  - no rx_valid pulse; rx_data keeps its previous value.
  - abort has priority over start in the same cycle.
- If abort and byte completion fall in the same cycle, abort wins: no rx_valid.
- rx_valid and tx_ready may be high in the same cycle when the next state is WAIT.
- tx_data and tx_last are don't-care except in the accept cycle.

Test Plan:
1. Single byte, CLK_DIV=2: start with tx_data=0xA5, tx_last=1; miso driven with 0x3C, changed on SCLK falling edges. Required:
   - mosi bits 1,0,1,0,0,1,0,1 seen on 8 rising edges;
   - rx_data=0x3C with one rx_valid pulse;
   - cs_n low for exactly 34 clk cycles; sclk low and cs_n high afterwards.
2. Two-byte transaction, CLK_DIV=1: bytes 0x01 (tx_last=0) and 0xFF (tx_last=1), second start issued in the first cycle tx_ready=1; miso=0x80 then 0x7E. Required:
   - cs_n never rises between bytes;
   - two rx_valid pulses with rx_data=0x80 then 0x7E;
   - exactly 16 SCLK rising edges total.
3. start pulsed while busy in LEAD/HIGH. Required: ignored; the transmitted byte is unchanged and no extra bytes are sent.
4. abort asserted after the 4th SCLK rise of byte 0x5A. Required:
   - next cycle cs_n=1, sclk=0, busy=0;
   - no rx_valid; rx_data retains its prior value.
5. rst_n dropped asynchronously mid-byte (between clk edges). Required:
   - immediately cs_n=1, sclk=0, mosi=0, rx_data=0x00, tx_ready=1;
   - a new start after release sends a full, correct byte.
6. CLK_DIV=255 with byte 0xC3, tx_last=1. Required:
   - SCLK half-period exactly 255 cycles;
   - cs_n low for 4335 cycles;
   - loopback with miso tied to mosi gives rx_data=0xC3.

Source files
------------

// File: rtl/spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// spi_host_ctrl : byte-wide SPI mode-0 initiator with ready/start handshake
// Revision      : 1.0
// ============================================================================
module spi_host_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       abort,
    output logic       tx_ready,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        WAIT  = 3'd3,
        TRAIL = 3'd4
    } state_e;

    state_e     state_q;
    logic [7:0] div_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sr_q;
    logic [7:0] rx_sr_q;
    logic [7:0] rx_data_q;
    logic       last_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       cs_n_q;
    logic       rx_valid_q;
    logic       phase_end;

    assign phase_end = (div_q == DIV_LAST);
    assign tx_ready  = (state_q == IDLE) || (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_sr_q    <= 8'd0;
            rx_sr_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            // Abort overrides everything, including a byte completing this cycle.
            if (abort) begin
                state_q <= IDLE;
                div_q   <= 8'd0;
                bit_q   <= 3'd0;
                sclk_q  <= 1'b0;
                mosi_q  <= 1'b0;
                cs_n_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, WAIT: begin
                        if (start) begin
                            tx_sr_q <= tx_data;
                            last_q  <= tx_last;
                            mosi_q  <= tx_data[7];
                            cs_n_q  <= 1'b0;
                            bit_q   <= 3'd0;
                            div_q   <= 8'd0;
                            state_q <= LEAD;
                        end
                    end
                    LEAD: begin
                        if (phase_end) begin
                            div_q   <= 8'd0;
                            sclk_q  <= 1'b1;
                            rx_sr_q <= {rx_sr_q[6:0], miso};
                            state_q <= HIGH;
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    HIGH: begin
                        if (phase_end) begin
                            div_q  <= 8'd0;
                            sclk_q <= 1'b0;
                            if (bit_q == 3'd7) begin
                                rx_data_q  <= rx_sr_q;
                                rx_valid_q <= 1'b1;
                                state_q    <= last_q ? TRAIL : WAIT;
                            end else begin
                                bit_q   <= bit_q + 3'd1;
                                tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                                mosi_q  <= tx_sr_q[6];
                                state_q <= LEAD;
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    TRAIL: begin
                        if (phase_end) begin
                            div_q   <= 8'd0;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
`default_nettype none
// tb_spi_host_ctrl : directed checks of spi_host_ctrl at CLK_DIV = 2, 1 and 255.
module tb_spi_host_ctrl;

    localparam int NDUT = 3;

    function automatic int div_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 255;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic [NDUT-1:0]      start, tx_last, abort, miso, loopback;
    logic [NDUT-1:0]      tx_ready, busy, rx_valid, sclk, mosi, cs_n;
    logic [NDUT-1:0][7:0] tx_data, rx_data;
    logic [15:0]          sword [NDUT];

    // Monitor state: cumulative per-instance counters, sampled on falling clk.
    logic [NDUT-1:0] prev_sclk = '0;
    logic [NDUT-1:0] prev_cs   = '1;
    logic [3:0]  fidx    [NDUT] = '{default: 4'd0};
    logic [15:0] mcap    [NDUT] = '{default: 16'd0};
    logic [7:0]  rv_last [NDUT] = '{default: 8'd0};
    logic [7:0]  rv_prev [NDUT] = '{default: 8'd0};
    int rises   [NDUT] = '{default: 0};
    int cs_low  [NDUT] = '{default: 0};
    int cs_rise [NDUT] = '{default: 0};
    int rv_cnt  [NDUT] = '{default: 0};
    int hi_run  [NDUT] = '{default: 0};
    int hi_tot  [NDUT] = '{default: 0};
    int hi_bad  [NDUT] = '{default: 0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        spi_host_ctrl #(.CLK_DIV(div_of(g))) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .tx_data  (tx_data[g]),
            .tx_last  (tx_last[g]),
            .abort    (abort[g]),
            .tx_ready (tx_ready[g]),
            .busy     (busy[g]),
            .rx_data  (rx_data[g]),
            .rx_valid (rx_valid[g]),
            .sclk     (sclk[g]),
            .mosi     (mosi[g]),
            .miso     (miso[g]),
            .cs_n     (cs_n[g])
        );
        // Target model: next bit presented after each SCLK fall, MSB first.
        assign miso[g] = loopback[g] ? mosi[g] : sword[g][~fidx[g]];
    end

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            prev_sclk[g] <= sclk[g];
            prev_cs[g]   <= cs_n[g];
            if (!cs_n[g]) cs_low[g] <= cs_low[g] + 1;
            if (cs_n[g] && !prev_cs[g]) cs_rise[g] <= cs_rise[g] + 1;
            if (rx_valid[g]) begin
                rv_cnt[g]  <= rv_cnt[g] + 1;
                rv_prev[g] <= rv_last[g];
                rv_last[g] <= rx_data[g];
            end
            if (sclk[g]) begin
                hi_run[g] <= hi_run[g] + 1;
                hi_tot[g] <= hi_tot[g] + 1;
            end
            if (sclk[g] && !prev_sclk[g]) begin
                rises[g] <= rises[g] + 1;
                mcap[g]  <= {mcap[g][14:0], mosi[g]};
            end
            if (!sclk[g] && prev_sclk[g]) begin
                if (hi_run[g] != div_of(g)) hi_bad[g] <= hi_bad[g] + 1;
                hi_run[g] <= 0;
            end
            if (cs_n[g]) fidx[g] <= 4'd0;
            else if (!sclk[g] && prev_sclk[g]) fidx[g] <= fidx[g] + 4'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int g, input logic [7:0] exp_rx);
        check({tag, "_cs_n"},     32'(cs_n[g]),     32'd1);
        check({tag, "_sclk"},     32'(sclk[g]),     32'd0);
        check({tag, "_mosi"},     32'(mosi[g]),     32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready[g]), 32'd1);
        check({tag, "_busy"},     32'(busy[g]),     32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid[g]), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data[g]),  32'(exp_rx));
    endtask

    task automatic send(input int g, input logic [7:0] d, input logic l);
        int n = 0;
        while (!tx_ready[g] && n < 10000) begin
            tick();
            n++;
        end
        check("send_ready", 32'(tx_ready[g]), 32'd1);
        start[g]   = 1'b1;
        tx_data[g] = d;
        tx_last[g] = l;
        tick();
        start[g]   = 1'b0;
        tx_data[g] = ~d;
        tx_last[g] = ~l;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy[g] && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy[g]), 32'd0);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mi;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_cs_low;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int rb, vb, cb, crb, hb, htb, n;
        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 34};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 34};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 34};
        vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 34};

        rst_n    = 1'b0;
        start    = '0;
        abort    = '0;
        tx_last  = '0;
        tx_data  = '0;
        loopback = '0;
        for (int g = 0; g < NDUT; g++) sword[g] = 16'h0000;
        repeat (3) tick();
        check_idle("in_reset", 0, 8'h00);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 0, 8'h00);

        // start pulses while the byte is in flight must be ignored
        rb = rises[0]; vb = rv_cnt[0];
        sword[0] = {8'h69, 8'h00};
        send(0, 8'h96, 1'b1);
        for (int i = 0; i < 8; i++) begin
            start[0]   = 1'b1;
            tx_data[0] = 8'h00;
            tx_last[0] = 1'b0;
            tick();
        end
        start[0] = 1'b0;
        wait_idle(0, 200);
        repeat (10) tick();
        check("busy_start_mosi",   32'(mcap[0][7:0]), 32'h96);
        check("busy_start_rises",  32'(rises[0] - rb), 32'd8);
        check("busy_start_rvalid", 32'(rv_cnt[0] - vb), 32'd1);
        check("busy_start_rx",     32'(rx_data[0]), 32'h69);
        check("busy_start_idle",   32'(busy[0]), 32'd0);

        // abort after the 4th rising edge
        rb = rises[0]; vb = rv_cnt[0];
        send(0, 8'h5A, 1'b1);
        n = 0;
        while ((rises[0] - rb) < 4 && n < 100) begin
            tick();
            n++;
        end
        check("abort_rise4", 32'(rises[0] - rb), 32'd4);
        abort[0] = 1'b1;
        tick();
        check_idle("abort", 0, 8'h69);
        abort[0] = 1'b0;
        repeat (20) tick();
        check("abort_no_rvalid", 32'(rv_cnt[0] - vb), 32'd0);
        check("abort_rx_keep",   32'(rx_data[0]), 32'h69);
        check("abort_rises",     32'(rises[0] - rb), 32'd4);

        // asynchronous reset between clock edges, SCLK high
        rb = rises[0];
        send(0, 8'hFF, 1'b0);
        n = 0;
        while ((rises[0] - rb) < 3 && n < 100) begin
            tick();
            n++;
        end
        check("areset_pre_sclk", 32'(sclk[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("areset", 0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // single-byte table at CLK_DIV=2
        for (int i = 0; i < 4; i++) begin
            rb = rises[0]; vb = rv_cnt[0]; cb = cs_low[0];
            sword[0] = {vecs[i].mi, 8'h00};
            send(0, vecs[i].tx, 1'b1);
            wait_idle(0, 200);
            tick();
            check("vec_rx",     32'(rx_data[0]), 32'(vecs[i].exp_rx));
            check("vec_rvalid", 32'(rv_cnt[0] - vb), 32'd1);
            check("vec_rises",  32'(rises[0] - rb), 32'd8);
            check("vec_mosi",   32'(mcap[0][7:0]), 32'(vecs[i].exp_mosi));
            check("vec_cs_low", 32'(cs_low[0] - cb), 32'(vecs[i].exp_cs_low));
            check("vec_sclk",   32'(sclk[0]), 32'd0);
            check("vec_cs_n",   32'(cs_n[0]), 32'd1);
        end

        // two-byte transaction at CLK_DIV=1, second start at first ready cycle
        rb = rises[1]; vb = rv_cnt[1]; cb = cs_low[1]; crb = cs_rise[1];
        sword[1] = 16'h807E;
        send(1, 8'h01, 1'b0);
        send(1, 8'hFF, 1'b1);
        wait_idle(1, 200);
        tick();
        check("two_rvalid",  32'(rv_cnt[1] - vb), 32'd2);
        check("two_rx0",     32'(rv_prev[1]), 32'h80);
        check("two_rx1",     32'(rv_last[1]), 32'h7E);
        check("two_rises",   32'(rises[1] - rb), 32'd16);
        check("two_cs_rise", 32'(cs_rise[1] - crb), 32'd1);
        check("two_cs_low",  32'(cs_low[1] - cb), 32'd34);
        check("two_mosi",    32'(mcap[1]), 32'h01FF);

        // CLK_DIV=255 with loopback
        rb = rises[2]; cb = cs_low[2]; hb = hi_bad[2]; htb = hi_tot[2];
        loopback[2] = 1'b1;
        send(2, 8'hC3, 1'b1);
        wait_idle(2, 6000);
        tick();
        check("slow_rx",      32'(rx_data[2]), 32'hC3);
        check("slow_cs_low",  32'(cs_low[2] - cb), 32'd4335);
        check("slow_rises",   32'(rises[2] - rb), 32'd8);
        check("slow_hi_runs", 32'(hi_bad[2] - hb), 32'd0);
        check("slow_hi_tot",  32'(hi_tot[2] - htb), 32'd2040);
        check("slow_sclk",    32'(sclk[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
